// File: rtl/clkdiv_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : clkdiv_seq_if
//  Purpose  : Bundle of the control/status signals between the CLKDIV
//             reset/calibration sequencer and its surroundings (PLL,
//             deserializer, system control, CLKDIV primitive).
//  Revision : 1.0 - initial release
// ============================================================================
interface clkdiv_seq_if #(
  parameter int MAX_CALIB = 8
);
  localparam int c_CCW = $clog2(MAX_CALIB + 1);

  logic             pll_lock;       // asynchronous PLL lock
  logic             align_ok;       // deserializer word-aligned flag
  logic             retrain;        // single-cycle rerun request
  logic             clkdiv_resetn;  // to CLKDIV RESETN
  logic             clkdiv_calib;   // to CLKDIV CALIB
  logic             ready;          // alignment achieved
  logic             error;          // retry limit exhausted
  logic [c_CCW-1:0] calib_count;    // CALIB pulses issued this run

  // Sequencer side
  modport slave (
    input  pll_lock,
    input  align_ok,
    input  retrain,
    output clkdiv_resetn,
    output clkdiv_calib,
    output ready,
    output error,
    output calib_count
  );

  // System/driver side
  modport master (
    output pll_lock,
    output align_ok,
    output retrain,
    input  clkdiv_resetn,
    input  clkdiv_calib,
    input  ready,
    input  error,
    input  calib_count
  );
endinterface
`default_nettype wire

// File: rtl/clkdiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : clkdiv_seq
//  Purpose  : Reset and calibration sequencer for the CLKDIV divided-clock
//             primitive. Waits for a filtered PLL lock, holds CLKDIV in reset,
//             releases it, lets the divided clock settle and then issues
//             single-cycle CALIB pulses until the deserializer reports word
//             alignment or the retry budget is exhausted.
//  Revision : 1.0 - initial release
// ============================================================================
module clkdiv_seq #(
  parameter int RST_CYCLES    = 16,  // cycles RESETN held low in HOLD (>=1)
  parameter int SETTLE_CYCLES = 64,  // settle time after release (>=1)
  parameter int CALIB_GAP     = 8,   // wait after each CALIB pulse (>=1)
  parameter int MAX_CALIB     = 8,   // CALIB pulse budget (>=1)
  parameter int LOCK_FILTER   = 4    // consecutive lock samples to leave IDLE (>=1)
) (
  input  wire logic   clk,
  input  wire logic   rst,
  clkdiv_seq_if.slave bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_CCW = $clog2(MAX_CALIB + 1);

  // One shared down-time counter serves HOLD, SETTLE and GAP; size it for the
  // longest of the three.
  localparam int c_CNT_MAX = (RST_CYCLES > SETTLE_CYCLES)
                           ? ((RST_CYCLES > CALIB_GAP) ? RST_CYCLES : CALIB_GAP)
                           : ((SETTLE_CYCLES > CALIB_GAP) ? SETTLE_CYCLES : CALIB_GAP);
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam int c_FILT_W  = $clog2(LOCK_FILTER + 1);

  localparam logic [c_CNT_W-1:0]  c_RST_LAST    = c_CNT_W'(RST_CYCLES - 1);
  localparam logic [c_CNT_W-1:0]  c_SETTLE_LAST = c_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0]  c_GAP_LAST    = c_CNT_W'(CALIB_GAP - 1);
  localparam logic [c_FILT_W-1:0] c_FILT_LAST   = c_FILT_W'(LOCK_FILTER - 1);
  localparam logic [c_CCW-1:0]    c_MAX_CALIB   = c_CCW'(MAX_CALIB);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,  // waiting for filtered lock, RESETN low
    S_HOLD   = 3'd1,  // RESETN held low for RST_CYCLES
    S_SETTLE = 3'd2,  // RESETN high, divided clock settling
    S_CHECK  = 3'd3,  // one-cycle look at align_ok
    S_CALIB  = 3'd4,  // one-cycle CALIB pulse
    S_GAP    = 3'd5,  // recovery wait after a pulse
    S_DONE   = 3'd6,  // aligned
    S_FAIL   = 3'd7   // pulse budget exhausted
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t             r_state;
  logic               r_sync1;        // first synchronizer flop
  logic               r_lock_s;       // synchronized lock
  logic [c_FILT_W-1:0] r_filt;        // consecutive lock-high samples in IDLE
  logic [c_CNT_W-1:0] r_cnt;          // HOLD / SETTLE / GAP timer
  logic               r_resetn;
  logic               r_calib;
  logic               r_ready;
  logic               r_error;
  logic [c_CCW-1:0]   r_calib_count;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  // Lock loss is only meaningful once we have left IDLE; in IDLE a low lock
  // simply restarts the filter.
  logic w_lock_lost;
  logic w_at_limit;

  assign w_lock_lost = (r_state != S_IDLE) && !r_lock_s;
  assign w_at_limit  = (r_calib_count == c_MAX_CALIB);

  // Sequencer: lock synchronizer, filter, timers, pulse counter and all
  // registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_sync1       <= 1'b0;
      r_lock_s      <= 1'b0;
      r_filt        <= '0;
      r_cnt         <= '0;
      r_resetn      <= 1'b0;
      r_calib       <= 1'b0;
      r_ready       <= 1'b0;
      r_error       <= 1'b0;
      r_calib_count <= '0;
    end else begin
      r_sync1  <= bus.pll_lock;
      r_lock_s <= r_sync1;

      if (w_lock_lost) begin
        // Losing lock overrides everything, including a pending retrain.
        r_state  <= S_IDLE;
        r_filt   <= '0;
        r_cnt    <= '0;
        r_resetn <= 1'b0;
        r_calib  <= 1'b0;
        r_ready  <= 1'b0;
        r_error  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_resetn <= 1'b0;
            r_calib  <= 1'b0;
            r_ready  <= 1'b0;
            r_error  <= 1'b0;
            if (r_lock_s) begin
              if (r_filt == c_FILT_LAST) begin
                r_state       <= S_HOLD;
                r_filt        <= '0;
                r_cnt         <= '0;
                r_calib_count <= '0;
              end else begin
                r_filt <= r_filt + c_FILT_W'(1);
              end
            end else begin
              r_filt <= '0;
            end
          end

          S_HOLD: begin
            if (r_cnt == c_RST_LAST) begin
              r_state  <= S_SETTLE;
              r_cnt    <= '0;
              r_resetn <= 1'b1;
            end else begin
              r_cnt <= r_cnt + c_CNT_W'(1);
            end
          end

          S_SETTLE: begin
            if (r_cnt == c_SETTLE_LAST) begin
              r_state <= S_CHECK;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + c_CNT_W'(1);
            end
          end

          S_CHECK: begin
            if (bus.align_ok) begin
              r_state <= S_DONE;
              r_ready <= 1'b1;
            end else if (w_at_limit) begin
              r_state <= S_FAIL;
              r_error <= 1'b1;
            end else begin
              // Pulse and count move together so calib_count already reflects
              // the pulse while CALIB is high.
              r_state       <= S_CALIB;
              r_calib       <= 1'b1;
              r_calib_count <= r_calib_count + c_CCW'(1);
            end
          end

          S_CALIB: begin
            r_state <= S_GAP;
            r_calib <= 1'b0;
            r_cnt   <= '0;
          end

          S_GAP: begin
            if (r_cnt == c_GAP_LAST) begin
              r_state <= S_CHECK;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + c_CNT_W'(1);
            end
          end

          S_DONE, S_FAIL: begin
            // Terminal states ignore align_ok; only retrain reruns the
            // sequence from HOLD.
            if (bus.retrain) begin
              r_state       <= S_HOLD;
              r_cnt         <= '0;
              r_resetn      <= 1'b0;
              r_ready       <= 1'b0;
              r_error       <= 1'b0;
              r_calib_count <= '0;
            end
          end

          default: begin
            r_state  <= S_IDLE;
            r_resetn <= 1'b0;
            r_calib  <= 1'b0;
            r_ready  <= 1'b0;
            r_error  <= 1'b0;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.clkdiv_resetn = r_resetn;
  assign bus.clkdiv_calib  = r_calib;
  assign bus.ready         = r_ready;
  assign bus.error         = r_error;
  assign bus.calib_count   = r_calib_count;

endmodule
`default_nettype wire

// File: doc/clkdiv_seq.md
# clkdiv_seq

Reset and calibration sequencer for the Gowin CLKDIV divided-clock primitive. It waits for a filtered PLL lock and holds CLKDIV in reset for a fixed time. It then releases reset, lets the divided clock settle, and issues single-cycle CALIB pulses until the downstream deserializer reports word alignment or a retry limit is reached. It sits directly upstream of the CLKDIV instance: it drives `resetn` and `calib`, and reports `ready` and `error` to system control.

## Interface
- `RST_CYCLES`, default 16: cycles `clkdiv_resetn` is held low in HOLD; must be ≥1.
- `SETTLE_CYCLES`, default 64: cycles waited after reset release before the first alignment check; must be ≥1.
- `CALIB_GAP`, default 8: wait cycles after each CALIB pulse before the next check; must be ≥1.
- `MAX_CALIB`, default 8: maximum CALIB pulses before declaring failure; must be ≥1.
- `LOCK_FILTER`, default 4: consecutive synchronized lock-high cycles required to leave IDLE.
- `clk`, in, 1: free-running sequencer clock. One clock domain only.
- `rst`, in, 1: reset, synchronous and active-high.
- `pll_lock`, in, 1: PLL lock, asynchronous. Passed through an internal 2-flop synchronizer to produce `lock_s`.
- `align_ok`, in, 1: word-aligned flag from the downstream deserializer, synchronous to `clk`.
- `retrain`, in, 1: single-cycle request to rerun the sequence.
- `clkdiv_resetn`, out, 1: drives CLKDIV RESETN.
- `clkdiv_calib`, out, 1: drives CLKDIV CALIB.
- `ready`, out, 1: alignment achieved.
- `error`, out, 1: retry limit exhausted.
- `calib_count`, out, $clog2(MAX_CALIB+1): number of CALIB pulses issued in the current run.

## Operation
- All outputs are registered.
- Reset values: `clkdiv_resetn`=0, `clkdiv_calib`=0, `ready`=0, `error`=0, `calib_count`=0, state=IDLE, synchronizer flops=0.
- **IDLE:** `resetn`=0. The lock filter counter increments while `lock_s`=1 and clears when `lock_s`=0. On the LOCK_FILTER-th consecutive high sample, go to HOLD.
- **HOLD:** `resetn`=0 for exactly RST_CYCLES cycles. `calib_count` clears on entry. Then go to SETTLE.
- **SETTLE:** `resetn`=1. Wait SETTLE_CYCLES cycles, then go to CHECK.
- **CHECK:** one cycle; samples `align_ok`.
  - `align_ok`=1: go to DONE.
  - Otherwise, if `calib_count`==MAX_CALIB: go to FAIL.
  - Otherwise: go to CALIB.
- **CALIB:** `clkdiv_calib`=1 for exactly one cycle. `calib_count` increments on the same edge. Then go to GAP.
- **GAP:** wait CALIB_GAP cycles, then go to CHECK.
- **DONE:** `ready`=1. Later changes of `align_ok` are ignored; software uses `retrain` to rerun.
- **FAIL:** `error`=1 and `resetn`=1, both held.
- **Lock loss:** `lock_s`=0 in any state other than IDLE has priority over everything else. Next state is IDLE, and on the next edge `resetn`=0, `calib`=0, `ready`=0, `error`=0.
- **Retrain:** `retrain`=1 in DONE or FAIL goes to HOLD and clears `ready` and `error`. `retrain` in any other state is ignored.
- **Simultaneous lock loss and retrain:** lock loss wins.
- **`rst` mid-sequence:** returns all outputs to their reset values on the next edge, including during a CALIB pulse. The pulse is truncated, never stretched.
- `clkdiv_calib` is never high while `clkdiv_resetn`=0.
- `calib_count` saturates at MAX_CALIB and never wraps.

## Timing
- Lock path: `pll_lock` rising reaches `lock_s` in 2 cycles. HOLD is entered LOCK_FILTER cycles after `lock_s` first goes high (lock held stable throughout).
- `clkdiv_resetn` rises exactly RST_CYCLES cycles after HOLD entry.
- First CHECK occurs SETTLE_CYCLES cycles after `resetn` rises.
- CALIB-to-CALIB spacing is CALIB_GAP+2 cycles (CALIB, GAP, CHECK).
- `ready` rises 1 cycle after a CHECK that samples `align_ok`=1.
- `error` rises 1 cycle after the CHECK with `calib_count`==MAX_CALIB and `align_ok`=0.

## Test plan
- **Clean bring-up:** `pll_lock`=1 from cycle 0, `align_ok`=1 throughout, defaults → `resetn` low for 16 cycles after HOLD entry; first CHECK 64 cycles after release; `ready`=1; `calib` never pulses; `calib_count`=0.
- **Alignment after 3 pulses:** `align_ok` rises during the third GAP → exactly 3 one-cycle `calib` pulses spaced 10 cycles apart; `ready`=1; `calib_count`=3.
- **Failure:** `align_ok`=0 forever → 8 pulses; `error`=1 one cycle after the ninth CHECK; `calib_count`=8; `ready`=0.
- **Lock glitch:** `pll_lock` drops for 1 cycle during SETTLE → `resetn`=0 within 3 cycles of the drop; full HOLD repeats after 4 stable lock cycles. Separately, a 2-cycle lock-high pulse in IDLE does not leave IDLE.
- **Retrain from FAIL:** pulse `retrain` in FAIL → `error` clears, `resetn`=0 for 16 cycles, `calib_count` clears, sequence reruns. Retrain in SETTLE is ignored.
- **Reset during CALIB:** `rst`=1 in the CALIB cycle → next edge has `calib`=0, `resetn`=0, and all outputs at their reset values.
